// File: rtl/shift_sequencer.sv
// Iterative 0-7 position logical right shifter built around one shared 1-bit shifter.
// Latency: out_valid in the cycle after accept edge + in_amt. Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Optional sticky (OR of shifted-out bits) built when STICKY_EN is defined; otherwise out_sticky is tied to 0.

module shift_sequencer_shr1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = {1'b0, d[W-1:1]};
endmodule

module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sticky,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] shr_q;
  logic [AMT_W-1:0]  cnt_r;

  shift_sequencer_shr1 #(.W(DATA_W)) u_shr1 (
    .d (data_r),
    .q (shr_q)
  );

  // Zero amount skips SHIFT entirely, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data_r <= '0;
      cnt_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            cnt_r  <= in_amt;
            state  <= (in_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_r <= shr_q;
          cnt_r  <= cnt_r - AMT_W'(1);
          if (cnt_r == AMT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STICKY_EN
  logic sticky_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sticky_r <= 1'b0;
    end else if (state == SHIFT) begin
      sticky_r <= sticky_r | data_r[0];
    end
  end

  assign out_sticky = sticky_r;
`else
  assign out_sticky = 1'b0;
`endif

  // Held low during reset so nothing is accepted while rst is asserted.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_data  = data_r;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised and directed bench for shift_sequencer against a plain-arithmetic shift model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_amt = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sticky;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer #(.DATA_W(8), .AMT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_data(input logic [7:0] d, input int a);
    return d >> a;
  endfunction

  function automatic logic model_sticky(input logic [7:0] d, input int a);
`ifdef STICKY_EN
    int mask;
    mask = (1 << a) - 1;
    return (int'(d) & mask) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Accept one operand, measure latency, hold out_ready low for 'hold' cycles, then release.
  task automatic run_op(input logic [7:0] d, input logic [2:0] a, input int hold,
                        output logic [7:0] od, output logic os, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    od = 8'h00;
    os = 1'b0;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    od = out_data;
    os = out_sticky;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || out_data !== od || out_sticky !== os) ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_data, out_sticky, busy, in_ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h s=%b busy=%b rdy=%b want all 0",
               out_valid, out_data, out_sticky, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [7:0] od; logic os; int lat; bit ok;
    logic [7:0] vd [3] = '{8'hB5, 8'h80, 8'hF8};
    logic [2:0] va [3] = '{3'd3, 3'd0, 3'd3};
    for (int i = 0; i < 3; i++) begin
      run_op(vd[i], va[i], 0, od, os, lat, ok);
      n_tests++;
      if (!ok || od !== model_data(vd[i], va[i]) || os !== model_sticky(vd[i], va[i]) || lat != int'(va[i])) begin
        n_fail++;
        $display("FAIL directed_%0d got ok=%0d d=%h s=%b lat=%0d want d=%h s=%b lat=%0d", i, ok, od, os, lat,
                 model_data(vd[i], va[i]), model_sticky(vd[i], va[i]), va[i]);
      end
    end
  endtask

  task automatic test_busy_max();
    int busy_cycles = 0;
    logic [7:0] od = 8'h00;
    logic os = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_amt = 3'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (busy && busy_cycles < 30) begin
      if (out_valid) begin
        od = out_data;
        os = out_sticky;
      end
      busy_cycles++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++;
    if (busy_cycles != 8 || od !== model_data(8'hFF, 7) || os !== model_sticky(8'hFF, 7)) begin
      n_fail++;
      $display("FAIL busy_max got busy=%0d d=%h s=%b want busy=8 d=%h s=%b", busy_cycles, od, os,
               model_data(8'hFF, 7), model_sticky(8'hFF, 7));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] od; logic os; int w;
    bit stable = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB5; in_amt = 3'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    od = out_data;
    os = out_sticky;
    in_valid = 1'b1; in_data = 8'h55; in_amt = 3'd1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || out_data !== od || out_sticky !== os || in_ready !== 1'b0) stable = 1'b0;
    end
    n_tests++;
    if (!stable || od !== model_data(8'hB5, 3) || os !== model_sticky(8'hB5, 3)) begin
      n_fail++;
      $display("FAIL backpressure_hold got stable=%0d d=%h s=%b want stable=1 d=%h s=%b", stable, od, os,
               model_data(8'hB5, 3), model_sticky(8'hB5, 3));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] od; logic os; int lat; bit ok;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB5; in_amt = 3'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_sticky, busy, in_ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_shift got v=%b d=%h s=%b busy=%b rdy=%b want all 0",
               out_valid, out_data, out_sticky, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard got late result/busy=1 want none");
    end
    run_op(8'h40, 3'd2, 0, od, os, lat, ok);
    n_tests++;
    if (!ok || od !== 8'h10 || os !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL reset_recover got ok=%0d d=%h s=%b lat=%0d want d=10 s=0 lat=2", ok, od, os, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] od; logic os; int lat; bit ok;
    run_op(8'hC3, 3'd1, 0, od, os, lat, ok);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_ready got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
    run_op(8'h3C, 3'd2, 0, od, os, lat, ok);
    n_tests++;
    if (!ok || od !== model_data(8'h3C, 2) || os !== model_sticky(8'h3C, 2) || lat != 2) begin
      n_fail++;
      $display("FAIL back_to_back_second got d=%h s=%b lat=%0d want d=%h s=%b lat=2", od, os, lat,
               model_data(8'h3C, 2), model_sticky(8'h3C, 2));
    end
  endtask

  task automatic test_random();
    logic [7:0] od; logic os; int lat; bit ok;
    logic [7:0] d; logic [2:0] a;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      run_op(d, a, int'($urandom_range(0, 3)), od, os, lat, ok);
      n_tests++;
      if (!ok || od !== model_data(d, a) || os !== model_sticky(d, a) || lat != int'(a)) begin
        n_fail++;
        $display("FAIL random_%0d in=%h amt=%0d got ok=%0d d=%h s=%b lat=%0d want d=%h s=%b lat=%0d",
                 i, d, a, ok, od, os, lat, model_data(d, a), model_sticky(d, a), a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_max();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative right-shift controller that sequences the shared 8-bit one-bit right shifter to perform a variable right shift of 0–7 positions. It is used for operand and product scaling in the approximate multiplier datapath. Each accepted operand is shifted one position per clock by reusing a single one-bit shifter instance, so no full barrel shifter is needed. Input and output use valid/ready handshakes, and an optional sticky bit supports bias-correcting rounding downstream.

## Interface
- DATA_W, 8, operand width; fixed at 8 to match the one-bit shifter
- AMT_W, 3, shift-amount width; maximum shift is 2^AMT_W − 1 = 7
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand and amount present
- in_ready  output  1  block can accept an operand
- in_data  input  8  operand
- in_amt  input  3  number of right-shift positions
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- out_data  output  8  in_data >> in_amt (logical shift, zero fill)
- out_sticky  output  1  OR of all bits shifted out
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Internal state: data_r[7:0], cnt_r[2:0], sticky_r, FSM {IDLE, SHIFT, DONE}.
- The datapath instantiates the one-bit right shifter with data_r as its input.
  - Each shift cycle: data_r ← shifter output, i.e. data_r >> 1 with MSB = 0.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - data_r ← in_data, cnt_r ← in_amt, sticky_r ← 0.
  - Next state is DONE if in_amt == 0, otherwise SHIFT.
- SHIFT, every cycle:
  - data_r shifts once.
  - sticky_r ← sticky_r | data_r[0] (uses the pre-shift bit).
  - cnt_r ← cnt_r − 1.
  - When cnt_r == 1 in the current cycle, next state is DONE.
- DONE: out_valid = 1; out_data = data_r; out_sticky = sticky_r.
  - On out_valid & out_ready, next state is IDLE.
- in_ready = 1 only in IDLE. An in_valid seen in SHIFT or DONE is ignored and not queued.
- out_data and out_sticky stay stable while out_valid is high and out_ready is low.
- Outputs are driven from registers or state decode only. There is no combinational path from in_* to out_*.
- Reset (asynchronous, takes effect immediately, including mid-SHIFT or mid-DONE):
  - State → IDLE; data_r, cnt_r and sticky_r → 0.
  - out_valid = 0, out_data = 0x00, out_sticky = 0, busy = 0.
  - in_ready = 0 while rst is high; in_ready = 1 from the first cycle after rst deasserts.
  - Any in-flight operation is discarded. Nothing is output for it.

## Timing
- Acceptance happens at edge k.
- out_valid is high in the cycle after edge k + in_amt.
  - amt = 0: out_valid is high in the cycle right after acceptance.
  - amt = 7: out_valid is high 8 cycles after the accept cycle.
- busy rises in the cycle after edge k and falls in the cycle after the output handshake edge.
- Output handshake at edge m → IDLE after edge m. The next accept is possible at edge m + 1.
- Best-case throughput: one operation every in_amt + 2 cycles.
- The count never wraps: SHIFT is never entered with cnt_r = 0.

## Configuration
- STICKY_EN defined:
  - sticky_r is implemented.
  - out_sticky reports the OR of shifted-out bits.
- STICKY_EN undefined:
  - sticky_r is not built.
  - out_sticky is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- in_data = 0xB5, in_amt = 3 → out_data = 0x16, out_sticky = 1 (STICKY_EN), out_valid in the cycle after accept edge + 3.
- in_data = 0x80, in_amt = 0 → out_data = 0x80, out_sticky = 0, out_valid the cycle after accept. Then in_data = 0xF8, in_amt = 3 → 0x1F, sticky 0.
- in_data = 0xFF, in_amt = 7 → out_data = 0x01, out_sticky = 1. busy is high for exactly 8 cycles when out_ready is held at 1.
- Backpressure: out_ready held low for 5 cycles in DONE → out_valid, out_data and out_sticky stay stable and in_ready = 0. An in_valid with 0x55 is ignored. The result is released on the first out_ready = 1.
- rst pulsed high 2 cycles into SHIFT for 0xB5/amt 6:
  - All outputs are 0 immediately and no result appears.
  - A following 0x40/amt 2 returns 0x10 with the normal latency.
- Build without STICKY_EN and repeat the first scenario → out_data = 0x16, out_sticky = 0, identical timing.
